buffer_fill_ctrl: RTL and testbench

// Fills the 512 x 16-bit capture buffer from SDRAM for the RAM test console.
// - On START, issues burst read requests to the SDRAM controller.
// - Writes each returned 16-bit beat into the buffer's MEM write port at consecutive halfword addresses.
// - Reports BUSY/DONE/ERR to the console, which then reads the buffer as 256 x 32-bit words.

---
 rtl/buffer_fill_ctrl.sv | 152 +++++++++++++++
 tb/tb_buffer_fill_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/buffer_fill_ctrl.sv
// buffer_fill_ctrl: fills the 512 x 16-bit capture buffer from SDRAM.
// Issues one burst read at a time, writes returned beats to consecutive
// halfword addresses, and reports BUSY/DONE/ERR to the RAM test console.
module buffer_fill_ctrl #(
    parameter int SDRAM_AW  = 24,
    parameter int BURST_LEN = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [SDRAM_AW-1:0] BASE_ADDR,
    input  logic [9:0]          COUNT,
    input  logic                ABORT,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic                RD_REQ,
    output logic [SDRAM_AW-1:0] RD_ADDR,
    input  logic                RD_ACK,
    input  logic                RD_VALID,
    input  logic [15:0]         RD_DATA,
    output logic                MEM_WE,
    output logic [8:0]          MEM_ADDR,
    output logic [15:0]         MEM_WD
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [9:0]          LAST_BEAT = 10'(BURST_LEN - 1);
    localparam logic [SDRAM_AW-1:0] ADDR_STEP = SDRAM_AW'(BURST_LEN);
    localparam logic [9:0]          MAX_FILL  = 10'd512;

    logic [2:0]          state;
    logic [SDRAM_AW-1:0] addr;
    logic [9:0]          remain;
    logic [8:0]          widx;
    logic [9:0]          beat;
    logic                err_q;
    logic                we_q;
    logic [8:0]          waddr_q;
    logic [15:0]         wd_q;

    logic       last_beat;
    logic       has_room;
    logic [9:0] remain_after;
    logic       stray;

    // Beat bookkeeping shared by DATA and DRAIN; stray beats are any arriving with no burst outstanding
    always_comb begin
        last_beat    = RD_VALID && (beat == LAST_BEAT);
        has_room     = (remain != '0);
        remain_after = remain - {9'd0, has_room};
        stray        = RD_VALID && ((state == S_IDLE) || (state == S_REQ) || (state == S_FIN));
    end

    // Control FSM, address/count tracking, sticky error and registered buffer write port
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            addr    <= '0;
            remain  <= '0;
            widx    <= '0;
            beat    <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wd_q    <= '0;
        end else begin
            we_q <= 1'b0;

            // An accepted START clears ERR, but a stray beat in that same cycle still flags it
            if (state == S_IDLE && START) begin
                err_q <= stray;
            end else if (stray) begin
                err_q <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        if (COUNT == '0) begin
                            state <= S_FIN;
                        end else begin
                            state  <= S_REQ;
                            addr   <= BASE_ADDR;
                            remain <= (COUNT > MAX_FILL) ? MAX_FILL : COUNT;
                            widx   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (RD_ACK) begin
                        addr  <= addr + ADDR_STEP;
                        beat  <= '0;
                        state <= ABORT ? S_DRAIN : S_DATA;
                    end else if (ABORT) begin
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (RD_VALID) begin
                        beat <= beat + 10'd1;
                        if (has_room && !ABORT) begin
                            we_q    <= 1'b1;
                            waddr_q <= widx;
                            wd_q    <= RD_DATA;
                            widx    <= widx + 9'd1;
                            remain  <= remain_after;
                        end
                    end
                    // Abort on the final beat of a burst leaves nothing to drain
                    if (ABORT) begin
                        state <= last_beat ? S_IDLE : S_DRAIN;
                    end else if (last_beat) begin
                        state <= (remain_after != '0) ? S_REQ : S_FIN;
                    end
                end
                S_DRAIN: begin
                    if (RD_VALID) begin
                        beat <= beat + 10'd1;
                        if (last_beat) begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and request outputs decoded from the current state
    always_comb begin
        BUSY     = (state != S_IDLE);
        DONE     = (state == S_FIN);
        RD_REQ   = (state == S_REQ);
        RD_ADDR  = (state == S_REQ) ? addr : '0;
        ERR      = err_q;
        MEM_WE   = we_q;
        MEM_ADDR = waddr_q;
        MEM_WD   = wd_q;
    end

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// Directed bench for buffer_fill_ctrl: acts as SDRAM controller and buffer,
// checking request addresses, write order/data, DONE, BUSY and ERR.
module tb_buffer_fill_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [23:0] BASE_ADDR;
    logic [9:0]  COUNT;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        RD_REQ;
    logic [23:0] RD_ADDR;
    logic        RD_ACK;
    logic        RD_VALID;
    logic [15:0] RD_DATA;
    logic        MEM_WE;
    logic [8:0]  MEM_ADDR;
    logic [15:0] MEM_WD;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    buffer_fill_ctrl #(.SDRAM_AW(24), .BURST_LEN(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR),
        .COUNT(COUNT), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_WD(MEM_WD)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample; every buffer write must be the next index in order
    task automatic tick();
        @(posedge CLK);
        #1;
        if (MEM_WE === 1'b1) begin
            chk("mem_addr", 32'(MEM_ADDR), 32'(wr_cnt & 511));
            chk("mem_wd", 32'(MEM_WD), 32'(16'h5A00 ^ 16'(wr_cnt)));
            wr_cnt++;
        end
        if (DONE === 1'b1) done_cnt++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk({tag, "_err"}, 32'(ERR), 0);
        chk({tag, "_rd_req"}, 32'(RD_REQ), 0);
        chk({tag, "_rd_addr"}, 32'(RD_ADDR), 0);
        chk({tag, "_mem_we"}, 32'(MEM_WE), 0);
        chk({tag, "_mem_addr"}, 32'(MEM_ADDR), 0);
        chk({tag, "_mem_wd"}, 32'(MEM_WD), 0);
    endtask

    // Full fill: answer each request after ack_dly cycles with 8 beats of data 5A00^beat_index
    task automatic run_fill(input logic [23:0] base, input int count, input int ack_dly);
        int n;
        int nb;
        int g;
        int t;
        logic [23:0] ea;
        n  = (count > 512) ? 512 : count;
        nb = (n + 7) / 8;
        g  = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        BASE_ADDR = base;
        COUNT     = 10'(count);
        START     = 1'b1;
        tick();
        START = 1'b0;
        for (int b = 0; b < nb; b++) begin
            t = 0;
            while (RD_REQ !== 1'b1 && t < 20) begin
                tick();
                t++;
            end
            chk("rd_req_seen", 32'(RD_REQ), 1);
            ea = base + 24'(8 * b);
            chk("rd_addr", 32'(RD_ADDR), 32'(ea));
            repeat (ack_dly) tick();
            if (ack_dly > 0) chk("rd_addr_stable", 32'(RD_ADDR), 32'(ea));
            RD_ACK = 1'b1;
            tick();
            RD_ACK = 1'b0;
            for (int k = 0; k < 8; k++) begin
                RD_VALID = 1'b1;
                RD_DATA  = 16'h5A00 ^ 16'(g);
                g++;
                tick();
            end
            RD_VALID = 1'b0;
        end
        tick();
        chk("fill_busy_after", 32'(BUSY), 0);
        chk("fill_done_count", 32'(done_cnt), 1);
        chk("fill_write_count", 32'(wr_cnt), 32'(n));
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; BASE_ADDR = '0; COUNT = '0; ABORT = 1'b0;
        RD_ACK = 1'b0; RD_VALID = 1'b0; RD_DATA = '0;
        repeat (3) tick();
        chk_all_zero("reset");
        RESET = 1'b0;
        tick();

        // Two bursts, delayed ack
        run_fill(24'h000100, 16, 3);
        // Partial last burst: 10 written, 6 dropped
        run_fill(24'h000400, 10, 1);

        // COUNT=0 goes straight to FIN without a request
        COUNT = 10'd0; START = 1'b1;
        tick();
        START = 1'b0;
        chk("zero_done", 32'(DONE), 1);
        chk("zero_rd_req", 32'(RD_REQ), 0);
        chk("zero_busy", 32'(BUSY), 1);
        tick();
        chk("zero_done_end", 32'(DONE), 0);
        chk("zero_busy_end", 32'(BUSY), 0);

        // Clamp to 512 halfwords
        run_fill(24'h001000, 700, 0);
        // Address wrap on second burst
        run_fill(24'hFFFFF8, 16, 2);

        // Abort on beat 3 of the first burst
        wr_cnt = 0; done_cnt = 0;
        BASE_ADDR = 24'h000200; COUNT = 10'd16; START = 1'b1;
        tick();
        START = 1'b0;
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        for (int k = 0; k < 8; k++) begin
            RD_VALID = 1'b1;
            RD_DATA  = 16'h5A00 ^ 16'(k);
            ABORT    = (k == 3);
            tick();
            if (k == 3) chk("abort_drain_busy", 32'(BUSY), 1);
        end
        RD_VALID = 1'b0; ABORT = 1'b0;
        chk("abort_idle", 32'(BUSY), 0);
        chk("abort_writes", 32'(wr_cnt), 3);
        chk("abort_no_done", 32'(done_cnt), 0);
        chk("abort_no_err", 32'(ERR), 0);
        tick();
        chk("abort_no_we", 32'(MEM_WE), 0);

        // Abort while requesting, no ack
        COUNT = 10'd8; START = 1'b1;
        tick();
        START = 1'b0;
        chk("req_abort_req_up", 32'(RD_REQ), 1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("req_abort_req_down", 32'(RD_REQ), 0);
        chk("req_abort_idle", 32'(BUSY), 0);

        // Stray beat in IDLE sets sticky ERR, cleared by next START
        RD_VALID = 1'b1;
        tick();
        RD_VALID = 1'b0;
        chk("err_set", 32'(ERR), 1);
        tick();
        tick();
        chk("err_held", 32'(ERR), 1);
        COUNT = 10'd0; START = 1'b1;
        tick();
        START = 1'b0;
        chk("err_cleared", 32'(ERR), 0);
        tick();

        // Reset mid-burst, then an in-flight beat flags ERR
        wr_cnt = 0;
        BASE_ADDR = 24'h000300; COUNT = 10'd16; START = 1'b1;
        tick();
        START = 1'b0;
        RD_ACK = 1'b1;
        tick();
        RD_ACK = 1'b0;
        for (int k = 0; k < 2; k++) begin
            RD_VALID = 1'b1;
            RD_DATA  = 16'h5A00 ^ 16'(k);
            tick();
        end
        RESET = 1'b1;
        RD_DATA = 16'h5A02;
        tick();
        chk_all_zero("mid_reset");
        RESET = 1'b0;
        tick();
        RD_VALID = 1'b0;
        chk("inflight_err", 32'(ERR), 1);
        chk("inflight_idle", 32'(BUSY), 0);
        chk("reset_writes", 32'(wr_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
